// File: rtl/conv_enc_arbiter.sv
// Round-robin arbiter that shares one external rate-1/2 convolutional
// encoder (8-bit message in, 16-bit code out) among NREQ requesters.
// One transaction is in flight at a time: grant, launch the encoder, wait
// for completion or timeout, then hold the response until the winner acks.
module conv_enc_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [8*NREQ-1:0]    msg_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [15:0]          rsp_code,
  output logic                 rsp_err,
  input  logic [NREQ-1:0]      rsp_ack,
  output logic                 enc_start,
  output logic [7:0]           enc_msg,
  input  logic [15:0]          enc_code,
  input  logic                 enc_done,
  output logic                 busy
);

  localparam int DATA_W = 8;
  localparam int CODE_W = 16;
  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    winner;
  logic [CNT_W-1:0]    wait_cnt;
  logic [IDX_W-1:0]    pick;
  logic [DATA_W-1:0]   msg_sel;
  logic                timeout_hit;
  logic                ack_hit;

  // Round-robin search: the candidate nearest after the last grant wins.
  // Scanning from farthest to nearest lets the nearest overwrite the rest.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0]  r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] cand;
    int               idx;
    sel = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx  = (int'(p) + k) % NREQ;
      cand = IDX_W'(idx);
      if (r[cand]) sel = cand;
    end
    return sel;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Arbitration winner, its message, and the WAIT/RESP exit conditions.
  always_comb begin
    pick    = rr_pick(req, ptr);
    msg_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == IDX_W'(i)) msg_sel = msg_in[i*DATA_W +: DATA_W];
    end
    timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));
    ack_hit     = rsp_ack[winner];
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; enc_done only matters in WAIT and beats the timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|req) state_next = LAUNCH;
      LAUNCH:  state_next = WAIT;
      WAIT:    if (enc_done || timeout_hit) state_next = RESP;
      RESP:    if (ack_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded directly from the state.
  always_comb begin
    enc_start = (state == LAUNCH);
    busy      = (state != IDLE);
  end

  // Transaction registers: grant/capture in IDLE, timeout count in WAIT,
  // response capture on WAIT exit, release on the winner's ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_code  <= '0;
      rsp_err   <= 1'b0;
      enc_msg   <= '0;
      wait_cnt  <= '0;
      ptr       <= IDX_W'(NREQ - 1);
      winner    <= '0;
    end else begin
      gnt <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt     <= onehot(pick);
            enc_msg <= msg_sel;
            winner  <= pick;
            ptr     <= pick;
          end
        end
        LAUNCH: begin
          wait_cnt <= '0;
        end
        WAIT: begin
          if (enc_done) begin
            rsp_code  <= enc_code;
            rsp_err   <= 1'b0;
            rsp_valid <= onehot(winner);
          end else if (timeout_hit) begin
            rsp_code  <= {CODE_W{1'b0}};
            rsp_err   <= 1'b1;
            rsp_valid <= onehot(winner);
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (ack_hit) begin
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
